mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
- Moore-style main control FSM for the multi-cycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback over 3–5 cycles per instruction.
- Drives every datapath enable and mux select, plus the 2-bit aluOp consumed by aluControl_32_bit.
- Stalls on a memory-ready handshake so slow instruction or data memory can be attached.

Parameters:
- STATE_W, 4, width of state register and state debug port.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; forces state FETCH on the next rising edge.
- opcode  in  6  instr[31:26] from the instruction register; sampled only in DECODE and EXECUTE-class states.
- memReady  in  1  memory completes the current access this cycle.
- pcWrite  out  1  unconditional PC load.
- pcWriteCond  out  1  PC load if ALU zero (beq).
- iorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memRead  out  1  memory read strobe.
- memWrite  out  1  memory write strobe.
- irWrite  out  1  instruction register load.
- memToReg  out  1  register write data select: 0 = ALUOut, 1 = MDR.
- regDst  out  1  destination select: 0 = rt, 1 = rd.
- regWrite  out  1  register file write.
- aluSrcA  out  1  ALU A select: 0 = PC, 1 = A.
- aluSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = signext, 11 = signext<<2.
- aluOp  out  2  00 add, 01 sub, 10 use funct field.
- pcSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  STATE_W  current state code, for debug.

Behaviour:
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXEC=6, RTWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
- Codes 12–15 are illegal and go to FETCH on the next edge with all outputs 0.
- Default: every output not listed for a state is 0.

FETCH:
- Outputs: memRead=1, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00, iorD=0.
- irWrite=pcWrite=memReady (gated combinationally).
- Next state: DECODE if memReady, else stay in FETCH.

DECODE:
- Outputs: aluSrcA=0, aluSrcB=11, aluOp=00 (branch target precompute).
- Next state by opcode:
  - 000000 -> RTEXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDIEX
  - any other -> FETCH (unsupported instruction is a no-op; PC has already advanced).

Memory path:
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00. Next: MEMRD if opcode=100011, else MEMWR.
- MEMRD: memRead=1, iorD=1. Hold until memReady, then MEMWB.
- MEMWB: regWrite=1, memToReg=1, regDst=0. Next: FETCH.
- MEMWR: memWrite=1, iorD=1. Hold until memReady, then FETCH. memWrite stays high for every stalled cycle.

R-type path:
- RTEXEC: aluSrcA=1, aluSrcB=00, aluOp=10. Next: RTWB.
- RTWB: regWrite=1, regDst=1, memToReg=0. Next: FETCH.

Branch and jump:
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01. Next: FETCH.
- JUMP: pcWrite=1, pcSource=10. Next: FETCH.

addi path:
- ADDIEX: aluSrcA=1, aluSrcB=10, aluOp=00. Next: ADDIWB.
- ADDIWB: regWrite=1, regDst=0, memToReg=0. Next: FETCH.

Reset and output timing:
- Reset value: state=0. Outputs follow FETCH; with memReady=0 that is memRead=1, aluSrcB=01, everything else 0.
- While reset=1, state stays FETCH regardless of memReady.
- Reset asserted mid-instruction, including during a stalled MEMWR, abandons the instruction; memWrite drops the cycle after the reset edge.
- All outputs are combinational decodes of the state register; only irWrite and pcWrite also depend on memReady.
- opcode is only valid after the IR loads, so it is never used in FETCH.

Instruction latencies (memReady=1 throughout):
- lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.

Decomposition:
- Shared package/include mips_defs: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI) and ALUOP_ADD/SUB/FUNCT, also used by aluControl_32_bit.
- State codes stay local to this module.
- Optional sub-module mips_control_outdec: pure state(+memReady) to control-word decoder. The FSM keeps only the state register and next-state logic.

Test Plan:
- Reset 2 cycles, memReady=1 -> state=0, memRead=1, aluSrcB=01, irWrite=pcWrite=1, regWrite=memWrite=0.
- opcode=000000, memReady=1 -> states 0,1,6,7,0; aluOp=10 in RTEXEC; regWrite=1 and regDst=1 in RTWB only.
- opcode=100011, memReady low 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; iorD=1 for 3 cycles; memToReg=1 in MEMWB.
- opcode=101011 then opcode=000100 -> sw: states 0,1,2,5,0 with memWrite=1 once; beq: states 0,1,8,0 with aluOp=01, pcWriteCond=1, pcSource=01.
- opcode=111111 -> states 0,1,0, with no regWrite/memWrite asserted; opcode=000010 -> state 9 with pcWrite=1, pcSource=10.
- memReady=0 in FETCH 3 cycles -> state held at 0, irWrite=pcWrite=0; reset asserted during stalled MEMWR -> next state=0, memWrite=0.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared MIPS definitions: opcode constants and ALU operation codes used by the
// multi-cycle control FSM and the ALU control decoder, plus datapath mux codes.
package mips_defs;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // aluOp codes consumed by aluControl_32_bit
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_control.sv
// Moore main control FSM for the multi-cycle MIPS datapath. The state register
// and next-state logic live in one clocked block; every control output is a
// combinational decode of the state, with only irWrite/pcWrite also gated by
// memReady so a stalled fetch neither loads the IR nor advances the PC.
module mips_multicycle_control
  import mips_defs::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               memReady,
  output logic               pcWrite,
  output logic               pcWriteCond,
  output logic               iorD,
  output logic               memRead,
  output logic               memWrite,
  output logic               irWrite,
  output logic               memToReg,
  output logic               regDst,
  output logic               regWrite,
  output logic               aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic [1:0]         aluOp,
  output logic [1:0]         pcSource,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXEC = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  state_t state_q;

  assign state = STATE_W'(state_q);

  // State register with next-state selection; opcode is only consulted once the IR holds it
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  if (memReady) state_q <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_RTYPE:     state_q <= S_RTEXEC;
            OP_LW, OP_SW: state_q <= S_MEMADR;
            OP_BEQ:       state_q <= S_BRANCH;
            OP_J:         state_q <= S_JUMP;
            OP_ADDI:      state_q <= S_ADDIEX;
            default:      state_q <= S_FETCH;  // unsupported: no-op, PC already advanced
          endcase
        end
        S_MEMADR: state_q <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (memReady) state_q <= S_MEMWB;
        S_MEMWB:  state_q <= S_FETCH;
        S_MEMWR:  if (memReady) state_q <= S_FETCH;
        S_RTEXEC: state_q <= S_RTWB;
        S_RTWB:   state_q <= S_FETCH;
        S_BRANCH: state_q <= S_FETCH;
        S_JUMP:   state_q <= S_FETCH;
        S_ADDIEX: state_q <= S_ADDIWB;
        S_ADDIWB: state_q <= S_FETCH;
        default:  state_q <= S_FETCH;  // illegal codes 12-15 recover to fetch
      endcase
    end
  end

  // Control-word decode of the current state; illegal codes drive everything low
  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    memToReg    = 1'b0;
    regDst      = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = SRCB_REG;
    aluOp       = ALUOP_ADD;
    pcSource    = PCSRC_ALU;
    case (state_q)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = SRCB_FOUR;
        irWrite = memReady;
        pcWrite = memReady;
      end
      S_DECODE: aluSrcB = SRCB_IMM_SH2;  // branch target precompute
      S_MEMADR, S_ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
      end
      S_MEMWB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
      end
      S_MEMWR: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
      end
      S_RTEXEC: begin
        aluSrcA = 1'b1;
        aluOp   = ALUOP_FUNCT;
      end
      S_RTWB: begin
        regWrite = 1'b1;
        regDst   = 1'b1;
      end
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = ALUOP_SUB;
        pcWriteCond = 1'b1;
        pcSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pcWrite  = 1'b1;
        pcSource = PCSRC_JUMP;
      end
      S_ADDIWB: regWrite = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: a table of per-cycle
// {inputs, expected state, expected control word} records driven through a
// scoreboard queue, plus hand-written latency measurements.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       memReady;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic       memToReg, regDst, regWrite, aluSrcA;
  logic [1:0] aluSrcB, aluOp, pcSource;
  logic [3:0] state;

  mips_multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
    .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
    .memToReg(memToReg), .regDst(regDst), .regWrite(regWrite),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .pcSource(pcSource), .state(state)
  );

  always #5 clk = ~clk;

  // Control word layout (msb..lsb): pcWrite pcWriteCond iorD memRead memWrite
  // irWrite memToReg regDst regWrite aluSrcA aluSrcB[1:0] aluOp[1:0] pcSource[1:0]
  localparam logic [15:0] W_FETCH0 = 16'h1010;  // memRead, aluSrcB=01
  localparam logic [15:0] W_FETCH1 = 16'h9410;  // + pcWrite, irWrite
  localparam logic [15:0] W_DECODE = 16'h0030;  // aluSrcB=11
  localparam logic [15:0] W_MEMADR = 16'h0060;  // aluSrcA, aluSrcB=10
  localparam logic [15:0] W_MEMRD  = 16'h3000;  // iorD, memRead
  localparam logic [15:0] W_MEMWB  = 16'h0280;  // memToReg, regWrite
  localparam logic [15:0] W_MEMWR  = 16'h2800;  // iorD, memWrite
  localparam logic [15:0] W_RTEXEC = 16'h0048;  // aluSrcA, aluOp=10
  localparam logic [15:0] W_RTWB   = 16'h0180;  // regDst, regWrite
  localparam logic [15:0] W_BRANCH = 16'h4045;  // pcWriteCond, aluSrcA, aluOp=01, pcSource=01
  localparam logic [15:0] W_JUMP   = 16'h8002;  // pcWrite, pcSource=10
  localparam logic [15:0] W_ADDIEX = 16'h0060;
  localparam logic [15:0] W_ADDIWB = 16'h0080;  // regWrite

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  exp_state;
    logic [15:0] exp_word;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic logic [15:0] ctrl_word();
    return {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
            regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic add(input logic rst, input logic [5:0] op, input logic mr,
                     input logic [3:0] st, input logic [15:0] w);
    vec_t v;
    v.rst = rst; v.op = op; v.mr = mr; v.exp_state = st; v.exp_word = w;
    vecs.push_back(v);
  endtask

  // Run one instruction with memReady=1 from FETCH and count edges until FETCH returns
  task automatic measure(input logic [5:0] op, input int exp_cycles, input string name);
    int  n = 0;
    bit  done = 0;
    @(negedge clk);
    reset = 1'b0; opcode = op; memReady = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
      n++;
      if (state == 4'd0) done = 1;
    end
    check(name, n, exp_cycles);
  endtask

  initial begin
    vec_t e;
    string tag;
    reset = 1'b1; opcode = 6'h00; memReady = 1'b1;

    // reset held two cycles with memReady=1
    add(1, 6'h00, 1, 0, W_FETCH1);
    add(1, 6'h00, 1, 0, W_FETCH1);
    // R-type: 0,1,6,7
    add(0, 6'h00, 1, 0, W_FETCH1);
    add(0, 6'h00, 1, 1, W_DECODE);
    add(0, 6'h00, 1, 6, W_RTEXEC);
    add(0, 6'h00, 1, 7, W_RTWB);
    // lw with two stalled MEMRD cycles: 0,1,2,3,3,3,4
    add(0, 6'h23, 1, 0, W_FETCH1);
    add(0, 6'h23, 1, 1, W_DECODE);
    add(0, 6'h23, 1, 2, W_MEMADR);
    add(0, 6'h23, 0, 3, W_MEMRD);
    add(0, 6'h23, 0, 3, W_MEMRD);
    add(0, 6'h23, 1, 3, W_MEMRD);
    add(0, 6'h23, 1, 4, W_MEMWB);
    // sw: 0,1,2,5
    add(0, 6'h2B, 1, 0, W_FETCH1);
    add(0, 6'h2B, 1, 1, W_DECODE);
    add(0, 6'h2B, 1, 2, W_MEMADR);
    add(0, 6'h2B, 1, 5, W_MEMWR);
    // beq: 0,1,8
    add(0, 6'h04, 1, 0, W_FETCH1);
    add(0, 6'h04, 1, 1, W_DECODE);
    add(0, 6'h04, 1, 8, W_BRANCH);
    // unsupported opcode: 0,1 then straight back to fetch
    add(0, 6'h3F, 1, 0, W_FETCH1);
    add(0, 6'h3F, 1, 1, W_DECODE);
    // j: 0,1,9
    add(0, 6'h02, 1, 0, W_FETCH1);
    add(0, 6'h02, 1, 1, W_DECODE);
    add(0, 6'h02, 1, 9, W_JUMP);
    // addi: 0,1,10,11
    add(0, 6'h08, 1, 0, W_FETCH1);
    add(0, 6'h08, 1, 1, W_DECODE);
    add(0, 6'h08, 1, 10, W_ADDIEX);
    add(0, 6'h08, 1, 11, W_ADDIWB);
    // fetch stalled three cycles, then proceeds
    add(0, 6'h2B, 0, 0, W_FETCH0);
    add(0, 6'h2B, 0, 0, W_FETCH0);
    add(0, 6'h2B, 0, 0, W_FETCH0);
    add(0, 6'h2B, 1, 0, W_FETCH1);
    // sw stalled in MEMWR, reset lands during the stall
    add(0, 6'h2B, 1, 1, W_DECODE);
    add(0, 6'h2B, 1, 2, W_MEMADR);
    add(0, 6'h2B, 0, 5, W_MEMWR);
    add(1, 6'h2B, 0, 5, W_MEMWR);
    add(0, 6'h2B, 0, 0, W_FETCH0);

    // first edge under reset brings the register out of X before checking
    @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst; opcode = vecs[i].op; memReady = vecs[i].mr;
      sb.push_back(vecs[i]);
      #1;
      e = sb.pop_front();
      tag = $sformatf("step%0d", i);
      check({tag, "_state"}, 32'(state), 32'(e.exp_state));
      check({tag, "_ctrl"}, 32'(ctrl_word()), 32'(e.exp_word));
    end

    // instruction latencies with memReady=1 (state is FETCH here)
    measure(6'h23, 5, "lat_lw");
    measure(6'h2B, 4, "lat_sw");
    measure(6'h00, 4, "lat_rtype");
    measure(6'h08, 4, "lat_addi");
    measure(6'h04, 3, "lat_beq");
    measure(6'h02, 3, "lat_j");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
